// File: rtl/bird_ctrl.sv
`default_nettype none
// ============================================================================
// bird_ctrl : button-to-command pulses, death detection, round FSM and score.
// Optional BIRD_CTRL_AUTOFALL_EN builds the post-jump automatic fall pulse.
// Revision 1.0
// ============================================================================
module bird_ctrl #(
    parameter int JUMP_GAP      = 10,
    parameter int FALL_DELAY    = 25,
    parameter int OVER_HOLD     = 100,
    parameter int Y_CEIL        = 0,
    parameter int Y_FLOOR       = 440,
    parameter int TICKS_PER_SEC = 100
) (
    input  logic        clk_100Hz,
    input  logic        rst_n,
    input  logic        btn,
    input  logic        hit,
    input  logic [8:0]  bird_y,
    output logic        start,
    output logic        jump,
    output logic        fall,
    output logic        kill,
    output logic [1:0]  game_state,
    output logic [13:0] score
);

    localparam int GAP_W  = $clog2(JUMP_GAP + 1);
    localparam int HOLD_W = $clog2(OVER_HOLD + 1);
    localparam int SEC_W  = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

    localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(JUMP_GAP - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(OVER_HOLD);
    localparam logic [SEC_W-1:0]  SEC_LAST  = SEC_W'(TICKS_PER_SEC - 1);
    localparam logic [8:0]        CEIL_Y    = 9'(Y_CEIL);
    localparam logic [8:0]        FLOOR_Y   = 9'(Y_FLOOR);
    localparam logic [13:0]       SCORE_MAX = 14'h3FFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_t;

    state_t             state;
    logic               btn_q;
    logic               btn_armed;
    logic [GAP_W-1:0]   gap_cnt;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [SEC_W-1:0]   sec_cnt;
    logic               press;
    logic               dead;

`ifdef BIRD_CTRL_AUTOFALL_EN
    localparam int FALL_W = $clog2(FALL_DELAY + 1);
    localparam logic [FALL_W-1:0] FALL_LOAD = FALL_W'(FALL_DELAY);
    logic [FALL_W-1:0]  fall_cnt;
    logic               fall_armed;
`else
    assign fall = 1'b0;
`endif

    // btn_armed blocks a level held high across reset release from looking like a press
    assign press      = btn && !btn_q && btn_armed;
    assign dead       = hit || (bird_y <= CEIL_Y) || (bird_y >= FLOOR_Y);
    assign game_state = state;

    always_ff @(posedge clk_100Hz) begin
        if (!rst_n) begin
            state      <= IDLE;
            btn_q      <= 1'b0;
            btn_armed  <= !btn;
            gap_cnt    <= '0;
            hold_cnt   <= '0;
            sec_cnt    <= '0;
            score      <= '0;
            start      <= 1'b0;
            jump       <= 1'b0;
            kill       <= 1'b0;
`ifdef BIRD_CTRL_AUTOFALL_EN
            fall       <= 1'b0;
            fall_cnt   <= '0;
            fall_armed <= 1'b0;
`endif
        end else begin
            btn_q <= btn;
            if (!btn) begin
                btn_armed <= 1'b1;
            end
            start <= 1'b0;
            jump  <= 1'b0;
            kill  <= 1'b0;
`ifdef BIRD_CTRL_AUTOFALL_EN
            fall  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    gap_cnt  <= '0;
                    sec_cnt  <= '0;
                    score    <= '0;
`ifdef BIRD_CTRL_AUTOFALL_EN
                    fall_cnt   <= '0;
                    fall_armed <= 1'b0;
`endif
                    if (press) begin
                        start <= 1'b1;
                        state <= PLAY;
                    end
                end

                PLAY: begin
                    if (dead) begin
                        kill     <= 1'b1;
                        state    <= OVER;
                        hold_cnt <= HOLD_LOAD;
                    end else begin
                        if (gap_cnt != '0) begin
                            gap_cnt <= gap_cnt - 1'b1;
                        end
`ifdef BIRD_CTRL_AUTOFALL_EN
                        if (fall_cnt != '0) begin
                            fall_cnt <= fall_cnt - 1'b1;
                        end
`endif
                        if (sec_cnt == SEC_LAST) begin
                            sec_cnt <= '0;
                            if (score != SCORE_MAX) begin
                                score <= score + 14'd1;
                            end
                        end else begin
                            sec_cnt <= sec_cnt + 1'b1;
                        end

                        // Later assignments override the decrements above
                        if (press && gap_cnt == '0) begin
                            jump    <= 1'b1;
                            gap_cnt <= GAP_LOAD;
`ifdef BIRD_CTRL_AUTOFALL_EN
                            fall_cnt   <= FALL_LOAD;
                            fall_armed <= 1'b1;
`endif
                        end
`ifdef BIRD_CTRL_AUTOFALL_EN
                        else if (!press && fall_armed && fall_cnt == '0) begin
                            fall       <= 1'b1;
                            fall_armed <= 1'b0;
                        end
`endif
                    end
                end

                OVER: begin
                    if (hold_cnt != '0) begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end else if (press) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bird_ctrl.sv
`default_nettype none
// ============================================================================
// tb_bird_ctrl : table-driven and sequence checks for bird_ctrl.
// Revision 1.0
// ============================================================================
module tb_bird_ctrl;

    logic        clk_100Hz = 1'b0;
    logic        rst_n     = 1'b0;
    logic        btn       = 1'b0;
    logic        hit       = 1'b0;
    logic [8:0]  bird_y    = 9'd200;
    logic        start, jump, fall, kill;
    logic [1:0]  game_state;
    logic [13:0] score;

    int errors = 0;
    int checks = 0;

`ifdef BIRD_CTRL_AUTOFALL_EN
    localparam bit AUTOFALL = 1'b1;
`else
    localparam bit AUTOFALL = 1'b0;
`endif

    bird_ctrl dut (
        .clk_100Hz  (clk_100Hz),
        .rst_n      (rst_n),
        .btn        (btn),
        .hit        (hit),
        .bird_y     (bird_y),
        .start      (start),
        .jump       (jump),
        .fall       (fall),
        .kill       (kill),
        .game_state (game_state),
        .score      (score)
    );

    always #5 clk_100Hz = ~clk_100Hz;

    typedef struct {
        logic       b;
        logic       h;
        logic [8:0] y;
        logic       s;
        logic       j;
        logic       k;
        logic [1:0] st;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic b, input logic h, input logic [8:0] y);
        btn    = b;
        hit    = h;
        bird_y = y;
        @(posedge clk_100Hz);
        #1;
    endtask

    // Reset, then start a round; leaves btn low one cycle into PLAY
    task automatic go_play();
        rst_n = 1'b0;
        step(1'b0, 1'b0, 9'd200);
        step(1'b0, 1'b0, 9'd200);
        check("rst_state", int'(game_state), 0);
        check("rst_score", int'(score), 0);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 9'd200);
        step(1'b1, 1'b0, 9'd200);
        check("gp_start", int'(start), 1);
        check("gp_state", int'(game_state), 1);
        step(1'b0, 1'b0, 9'd200);
    endtask

    initial begin
        vec_t vecs[10];
        vecs[0] = '{1'b1, 1'b0, 9'd200, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[1] = '{1'b1, 1'b1, 9'd440, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[2] = '{1'b0, 1'b0, 9'd200, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[3] = '{1'b1, 1'b0, 9'd200, 1'b1, 1'b0, 1'b0, 2'd1};
        vecs[4] = '{1'b1, 1'b0, 9'd200, 1'b0, 1'b0, 1'b0, 2'd1};
        vecs[5] = '{1'b0, 1'b0, 9'd200, 1'b0, 1'b0, 1'b0, 2'd1};
        vecs[6] = '{1'b1, 1'b0, 9'd439, 1'b0, 1'b1, 1'b0, 2'd1};
        vecs[7] = '{1'b0, 1'b0, 9'd1,   1'b0, 1'b0, 1'b0, 2'd1};
        vecs[8] = '{1'b1, 1'b0, 9'd0,   1'b0, 1'b0, 1'b1, 2'd2};
        vecs[9] = '{1'b0, 1'b0, 9'd0,   1'b0, 1'b0, 1'b0, 2'd2};

        // Reset with the button held high through release
        rst_n = 1'b0;
        step(1'b1, 1'b0, 9'd200);
        step(1'b1, 1'b0, 9'd200);
        check("reset_state", int'(game_state), 0);
        check("reset_score", int'(score), 0);
        check("reset_pulses", int'({start, jump, fall, kill}), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            step(vecs[i].b, vecs[i].h, vecs[i].y);
            check($sformatf("vec%0d_start", i), int'(start), int'(vecs[i].s));
            check($sformatf("vec%0d_jump", i), int'(jump), int'(vecs[i].j));
            check($sformatf("vec%0d_fall", i), int'(fall), 0);
            check($sformatf("vec%0d_kill", i), int'(kill), int'(vecs[i].k));
            check($sformatf("vec%0d_state", i), int'(game_state), int'(vecs[i].st));
        end

        // Jump gap and auto-fall: presses at cycles 0, 5, 10
        go_play();
        for (int c = 0; c <= 45; c++) begin
            step((c == 0 || c == 5 || c == 10), 1'b0, 9'd200);
            check($sformatf("gap_jump_c%0d", c), int'(jump), int'(c == 0 || c == 10));
            check($sformatf("autofall_c%0d", c), int'(fall), int'(AUTOFALL && c == 36));
        end

        // Press together with hit
        go_play();
        step(1'b1, 1'b1, 9'd200);
        check("simul_kill", int'(kill), 1);
        check("simul_jump", int'(jump), 0);
        check("simul_state", int'(game_state), 2);

        // Score accumulation then floor death
        go_play();
        for (int c = 0; c < 350; c++) begin
            step(1'b0, 1'b0, 9'd200);
        end
        check("score_350", int'(score), 3);
        check("score_state", int'(game_state), 1);
        step(1'b0, 1'b0, 9'd440);
        check("floor_kill", int'(kill), 1);
        check("floor_state", int'(game_state), 2);
        check("floor_score", int'(score), 3);

        // OVER hold: early press ignored, late press returns to IDLE silently
        for (int c = 0; c < 49; c++) begin
            step(1'b0, 1'b0, 9'd440);
        end
        check("over_no_rekill", int'(kill), 0);
        step(1'b1, 1'b0, 9'd440);
        check("hold_press_state", int'(game_state), 2);
        check("hold_press_start", int'(start), 0);
        for (int c = 0; c < 60; c++) begin
            step(1'b0, 1'b0, 9'd440);
        end
        check("over_score_frozen", int'(score), 3);
        step(1'b1, 1'b0, 9'd200);
        check("over_exit_state", int'(game_state), 0);
        check("over_exit_start", int'(start), 0);
        step(1'b0, 1'b0, 9'd200);
        check("idle_score_clear", int'(score), 0);
        step(1'b1, 1'b0, 9'd200);
        check("restart_start", int'(start), 1);
        check("restart_state", int'(game_state), 1);
        check("restart_score", int'(score), 0);

        // Mid-round reset is covered inside go_play's reset checks
        step(1'b0, 1'b0, 9'd200);
        step(1'b0, 1'b0, 9'd200);
        go_play();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
